// File: rtl/bit_unstuff_pkg.sv
// Shared constants and FSM encoding for the full-speed bit stuffer and unstuffer.
package bit_unstuff_pkg;

    localparam int unsigned DEF_SYNC_ZEROS = 5;
    localparam int unsigned DEF_MAX_ONES   = 6;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_EOP   = 2'd2,
        ST_ABORT = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_byte_assembler.sv
// Collects unstuffed serial bits LSB-first into bytes and strobes each completed byte.
module rx_byte_assembler
    import bit_unstuff_pkg::*;
(
    input  logic              gclk,
    input  logic              reset_l,
    input  logic              clr,
    input  logic              bit_en,
    input  logic              bit_din,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_byte_valid,
    output logic [CNT_W-1:0]  bit_cnt
);

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            bit_cnt       <= '0;
        end else begin
            rx_byte_valid <= 1'b0;
            if (clr) begin
                bit_cnt <= '0;
            end else if (bit_en) begin
                // Right shift so the first received bit lands in bit 0 after eight bits
                rx_byte <= {bit_din, rx_byte[BYTE_W-1:1]};
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (bit_cnt == '1) begin
                    rx_byte_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bit_unstuff.sv
// Receive-side SYNC hunt, stuffed-zero removal, stuffing-violation and EOP detection.
module bit_unstuff
    import bit_unstuff_pkg::*;
#(
    parameter int unsigned SYNC_ZEROS = DEF_SYNC_ZEROS,
    parameter int unsigned MAX_ONES   = DEF_MAX_ONES
) (
    input  logic              gclk,
    input  logic              reset_l,
    input  logic              rx_en,
    input  logic              rxd,
    input  logic              rx_se0,
    input  logic              rx_bit_valid,
    output logic              unstuff_dout,
    output logic              unstuff_valid,
    output logic              halt_rx_shift,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_byte_valid,
    output logic              rx_active,
    output logic              stuff_err,
    output logic              eop_det,
    output logic              byte_align_err
);

    rx_state_t        state;
    logic [CNT_W-1:0] zero_cnt;
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic             abort_se0;
    logic             at_max_c;
    logic             emit_c;
    logic             asm_clr_c;

    assign at_max_c  = (ones_cnt == CNT_W'(MAX_ONES));
    // Assembler sees the data bit in the same cycle it is accepted so the byte strobe lines up with unstuff_valid
    assign emit_c    = rx_bit_valid && (state == ST_DATA) && !rx_se0 && !at_max_c;
    assign asm_clr_c = !rx_en || (state == ST_IDLE);

    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state          <= ST_IDLE;
            zero_cnt       <= '0;
            ones_cnt       <= '0;
            abort_se0      <= 1'b0;
            unstuff_dout   <= 1'b0;
            unstuff_valid  <= 1'b0;
            halt_rx_shift  <= 1'b0;
            rx_active      <= 1'b0;
            stuff_err      <= 1'b0;
            eop_det        <= 1'b0;
            byte_align_err <= 1'b0;
        end else begin
            unstuff_valid  <= 1'b0;
            halt_rx_shift  <= 1'b0;
            stuff_err      <= 1'b0;
            eop_det        <= 1'b0;
            byte_align_err <= 1'b0;
            if (!rx_en) begin
                state     <= ST_IDLE;
                zero_cnt  <= '0;
                ones_cnt  <= '0;
                abort_se0 <= 1'b0;
                rx_active <= 1'b0;
            end else if (rx_bit_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_se0) begin
                            zero_cnt <= '0;
                        end else if (!rxd) begin
                            if (zero_cnt != '1) zero_cnt <= zero_cnt + CNT_W'(1);
                        end else begin
                            zero_cnt <= '0;
                            // SYNC terminator is not emitted but counts as the first 1 for stuffing
                            if (zero_cnt >= CNT_W'(SYNC_ZEROS)) begin
                                state     <= ST_DATA;
                                rx_active <= 1'b1;
                                ones_cnt  <= CNT_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (rx_se0) begin
                            state <= ST_EOP;
                        end else if (at_max_c) begin
                            if (rxd) begin
                                stuff_err <= 1'b1;
                                abort_se0 <= 1'b0;
                                state     <= ST_ABORT;
                            end else begin
                                halt_rx_shift <= 1'b1;
                                ones_cnt      <= '0;
                            end
                        end else begin
                            unstuff_valid <= 1'b1;
                            unstuff_dout  <= rxd;
                            ones_cnt      <= rxd ? ones_cnt + CNT_W'(1) : '0;
                        end
                    end
                    ST_EOP: begin
                        if (!rx_se0) begin
                            if (rxd) begin
                                eop_det        <= 1'b1;
                                byte_align_err <= (bit_cnt != '0);
                                rx_active      <= 1'b0;
                                state          <= ST_IDLE;
                            end else begin
                                stuff_err <= 1'b1;
                                abort_se0 <= 1'b0;
                                state     <= ST_ABORT;
                            end
                        end
                    end
                    ST_ABORT: begin
                        // Leave only on SE0 followed directly by J
                        if (rx_se0) begin
                            abort_se0 <= 1'b1;
                        end else if (abort_se0 && rxd) begin
                            abort_se0 <= 1'b0;
                            rx_active <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            abort_se0 <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    rx_byte_assembler u_asm (
        .gclk          (gclk),
        .reset_l       (reset_l),
        .clr           (asm_clr_c),
        .bit_en        (emit_c),
        .bit_din       (rxd),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .bit_cnt       (bit_cnt)
    );

endmodule
